// File: rtl/argon_pkg.sv
// Shared types and constants for the argon fetch front end.
package argon_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic single-beat Wishbone read channel between the fetch unit and the instruction ROM.
interface wishbone_if;
  import argon_pkg::*;

  logic            cycle;
  logic            strobe;
  logic [XLEN-1:0] address;
  logic            ack;
  logic [XLEN-1:0] data_out;

  modport master (output cycle, output strobe, output address, input ack, input data_out);
  modport slave  (input cycle, input strobe, input address, output ack, output data_out);

endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head is presented straight from storage registers.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: popping an empty FIFO or pushing a full one is ignored.
  always_comb begin
    do_pop_s  = pop && (count_r != {(PW+1){1'b0}});
    do_push_s = push && (count_r < DEPTH_C);
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
    end
  end

  assign head_valid = (count_r != {(PW+1){1'b0}});
  assign head_data  = mem_r[rd_ptr_r];
  assign count      = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction prefetcher: Wishbone master feeding a small FIFO toward decode,
// with redirect support that flushes prefetched words and restarts at a new PC.
module instr_fetch_unit
  import argon_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  wishbone_if.master        wishbone,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [XLEN-1:0]   instr_data,
  output logic [XLEN-1:0]   instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_t      state_r;
  fetch_state_t      state_s;
  logic [XLEN-1:0]   fetch_pc_r;
  logic [XLEN-1:0]   fetch_pc_s;
  logic [XLEN-1:0]   address_r;
  logic [XLEN-1:0]   address_s;
  logic [XLEN-1:0]   target_pc_s;
  logic              discard_r;
  logic              discard_s;
  logic              cycle_r;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;
  logic [CW-1:0]     fifo_count_s;
  logic [CW:0]       occupancy_s;
  logic [2*XLEN-1:0] head_s;

  assign target_pc_s = align_word(redirect_pc);
  assign pop_s       = instr_valid & instr_ready;

  // Next-state, fetch pointer, discard flag and FIFO control.
  always_comb begin
    state_s     = state_r;
    fetch_pc_s  = fetch_pc_r;
    discard_s   = discard_r;
    address_s   = address_r;
    push_s      = 1'b0;
    flush_s     = 1'b0;
    occupancy_s = {(CW+1){1'b0}};
    case (state_r)
      IDLE: begin
        if (redirect_valid) begin
          flush_s    = 1'b1;
          fetch_pc_s = target_pc_s;
          address_s  = target_pc_s;
          state_s    = REQ;
        end else if ({1'b0, fifo_count_s} < DEPTH_C) begin
          address_s = fetch_pc_r;
          state_s   = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (wishbone.ack) begin
          if (redirect_valid) begin
            flush_s    = 1'b1;
            discard_s  = 1'b0;
            fetch_pc_s = target_pc_s;
          end else if (discard_r) begin
            // Word belongs to the pre-redirect stream; fetch_pc already holds the target.
            discard_s = 1'b0;
          end else begin
            push_s     = 1'b1;
            fetch_pc_s = fetch_pc_r + 32'd4;
          end
          address_s = fetch_pc_s;
          if (flush_s) begin
            occupancy_s = {(CW+1){1'b0}};
          end else begin
            occupancy_s = {1'b0, fifo_count_s} + (CW+1)'(push_s) - (CW+1)'(pop_s);
          end
          if (occupancy_s < DEPTH_C) begin
            state_s = REQ;
          end else begin
            state_s = IDLE;
          end
        end else begin
          if (redirect_valid) begin
            flush_s    = 1'b1;
            discard_s  = 1'b1;
            fetch_pc_s = target_pc_s;
          end else begin
            discard_s = discard_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered Wishbone drive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      discard_r  <= 1'b0;
      address_r  <= RESET_PC;
      cycle_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      discard_r  <= discard_s;
      address_r  <= address_s;
      cycle_r    <= (state_s == REQ);
    end
  end

  assign wishbone.cycle   = cycle_r;
  assign wishbone.strobe  = cycle_r;
  assign wishbone.address = address_r;

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush_s),
    .push       (push_s),
    .push_data  ({fetch_pc_r, wishbone.data_out}),
    .pop        (pop_s),
    .head_valid (instr_valid),
    .head_data  (head_s),
    .count      (fifo_count_s)
  );

  assign instr_pc   = head_s[2*XLEN-1:XLEN];
  assign instr_data = head_s[XLEN-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a 3-cycle Wishbone ROM, a program-order stream model, and directed scenarios.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import argon_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  int total = 0;
  int bad = 0;
  int ack_n = 0;
  logic        rst_sampled = 1'b0;
  logic [1:0]  rom_phase = 2'd0;

  wishbone_if wb();

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .wishbone       (wb),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + {24'd0, a[9:2]};
  endfunction

  // ROM slave: idle -> transaction -> ack; dropping cycle aborts the access.
  always @(posedge clk) begin
    if (!(wb.cycle && wb.strobe)) rom_phase <= 2'd0;
    else begin
      case (rom_phase)
        2'd0:    rom_phase <= 2'd1;
        2'd1:    rom_phase <= 2'd2;
        default: rom_phase <= 2'd0;
      endcase
    end
  end
  assign wb.ack      = (rom_phase == 2'd2) && wb.cycle && wb.strobe;
  assign wb.data_out = (rom_phase == 2'd2) ? rom_word(wb.address) : 32'h0;

  always @(posedge clk) begin
    rst_sampled <= reset;
    if (reset && wb.ack) ack_n <= ack_n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget, output int lat);
    lat = 0;
    while (!instr_valid && lat < budget) begin
      step();
      lat++;
    end
    if (!instr_valid) begin
      total++;
      bad++;
      $display("FAIL %s: no instr_valid within %0d cycles (got 0 expected 1)", name, budget);
    end
  endtask

  // Program-order model: the visible head must always be the next PC decode expects.
  initial begin : monitor
    logic [31:0] exp_pc;
    logic        hold_prev;
    logic [31:0] addr_prev;
    exp_pc = RPC;
    hold_prev = 1'b0;
    addr_prev = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_sampled) begin
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_cycle", 32'(wb.cycle), 32'd0);
        chk("rst_addr", wb.address, RPC);
        hold_prev = 1'b0;
      end else begin
        chk("strobe_eq_cycle", 32'(wb.strobe), 32'(wb.cycle));
        if (hold_prev) begin
          chk("held_strobe", 32'(wb.strobe), 32'd1);
          chk("held_addr", wb.address, addr_prev);
        end
        if (instr_valid) begin
          chk("head_pc", instr_pc, exp_pc);
          chk("head_data", instr_data, rom_word(instr_pc));
        end
        hold_prev = wb.cycle && wb.strobe && !wb.ack;
        addr_prev = wb.address;
      end
      if (!reset) exp_pc = RPC;
      else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    int base;
    int pops;
    logic found;

    // 1: reset release, streaming at one word per three cycles
    reset = 1'b0; instr_ready = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("t1_strobe", 32'(wb.strobe), 32'd1);
    chk("t1_addr", wb.address, 32'h0);
    wait_valid("t1_first", 20, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_pc0", instr_pc, 32'h0);
    chk("t1_data0", instr_data, 32'hA000_0000);
    step(); wait_valid("t1_second", 20, lat);
    chk("t1_gap1", 32'(lat + 1), 32'd3);
    chk("t1_pc1", instr_pc, 32'h4);
    chk("t1_data1", instr_data, 32'hA000_0001);
    step(); wait_valid("t1_third", 20, lat);
    chk("t1_gap2", 32'(lat + 1), 32'd3);
    chk("t1_pc2", instr_pc, 32'h8);

    // 2: decode stalled, FIFO fills and fetch stops
    reset = 1'b0; instr_ready = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    base = ack_n;
    repeat (25) step();
    chk("t2_pushes", 32'(ack_n - base), 32'd4);
    chk("t2_cycle_low", 32'(wb.cycle), 32'd0);
    chk("t2_head", instr_pc, 32'h0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t2_after_pop", instr_pc, 32'h4);
    step();
    chk("t2_refill_cyc", 32'(wb.cycle), 32'd1);
    chk("t2_refill_addr", wb.address, 32'h10);

    // 3: redirect while the first request is outstanding
    reset = 1'b0; instr_ready = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    chk("t3_ack_seen", 32'(wb.ack), 32'd1);
    chk("t3_addr_held", wb.address, 32'h0);
    step();
    chk("t3_new_addr", wb.address, 32'h100);
    chk("t3_cycle", 32'(wb.cycle), 32'd1);
    wait_valid("t3_first", 20, lat);
    chk("t3_pc", instr_pc, 32'h100);
    chk("t3_data", instr_data, 32'hA000_0040);

    // 4: redirect coinciding with an ack, two words already queued
    reset = 1'b0; instr_ready = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    base = ack_n;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (wb.ack && (ack_n - base) == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_third_ack", 32'(found), 32'd1);
    chk("t4_head_before", instr_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk("t4_flushed", 32'(instr_valid), 32'd0);
    chk("t4_new_addr", wb.address, 32'h200);
    chk("t4_cycle", 32'(wb.cycle), 32'd1);
    wait_valid("t4_first", 20, lat);
    chk("t4_pc", instr_pc, 32'h200);
    chk("t4_data", instr_data, 32'hA000_0080);

    // 5: reset during a ROM transaction
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rom_phase == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_in_transaction", 32'(found), 32'd1);
    reset = 1'b0;
    step();
    chk("t5_cycle", 32'(wb.cycle), 32'd0);
    chk("t5_strobe", 32'(wb.strobe), 32'd0);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_addr", wb.address, RPC);
    step();
    reset = 1'b1;
    step();
    chk("t5_restart_addr", wb.address, 32'h0);
    wait_valid("t5_first", 20, lat);
    chk("t5_pc", instr_pc, 32'h0);
    chk("t5_data", instr_data, 32'hA000_0000);

    // 6: fetch PC wraps past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_valid("t6_first", 20, lat);
    chk("t6_pc_top", instr_pc, 32'hFFFF_FFFC);
    chk("t6_data_top", instr_data, 32'hA000_00FF);
    step();
    wait_valid("t6_second", 20, lat);
    chk("t6_pc_wrap", instr_pc, 32'h0);
    chk("t6_data_wrap", instr_data, 32'hA000_0000);
    chk("t6_pc_known", 32'($isunknown(instr_pc)), 32'd0);

    // Random traffic: stalls, redirects (some near the wrap point), occasional resets.
    pops = 0;
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else redirect_pc = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        redirect_valid = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
      end
      if (instr_valid && instr_ready) pops++;
      step();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 32'(pops > 100), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
